// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Supports flush and a saturating stall-cycle counter. o_ready is registered, which breaks the backpressure path.
module pipe_stage_reg #(
    parameter int                    DATA_WIDTH  = 64,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                    CNT_WIDTH   = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_ready,
    input  logic                  i_flush,
    input  logic                  i_clear_count,
    output logic [1:0]            o_occupancy,
    output logic [CNT_WIDTH-1:0]  o_stall_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_main;
    logic [DATA_WIDTH-1:0] r_skid;
    logic                  r_valid;
    logic                  r_ready;
    logic [1:0]            r_occ;
    logic [CNT_WIDTH-1:0]  r_stall_cnt;

    logic w_in_fire;
    logic w_out_fire;
    logic w_stall;

    // Counter holds at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v)
            return v;
        return v + CNT_WIDTH'(1);
    endfunction

    assign w_in_fire  = i_valid & r_ready;
    assign w_out_fire = r_valid & i_ready;
    assign w_stall    = r_valid & ~i_ready;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_EMPTY;
            r_main  <= RESET_VALUE;
            r_skid  <= RESET_VALUE;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_occ   <= 2'd0;
        end else if (i_flush) begin
            // Payload registers are left untouched; o_data is don't-care while o_valid is low.
            r_state <= ST_EMPTY;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_occ   <= 2'd0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        r_main  <= i_data;
                        r_state <= ST_ONE;
                        r_valid <= 1'b1;
                        r_ready <= 1'b1;
                        r_occ   <= 2'd1;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main <= i_data;
                    end else if (w_in_fire) begin
                        // Downstream stalled: park the new payload behind the main entry.
                        r_skid  <= i_data;
                        r_state <= ST_FULL;
                        r_ready <= 1'b0;
                        r_occ   <= 2'd2;
                    end else if (w_out_fire) begin
                        r_state <= ST_EMPTY;
                        r_valid <= 1'b0;
                        r_occ   <= 2'd0;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        r_main  <= r_skid;
                        r_state <= ST_ONE;
                        r_ready <= 1'b1;
                        r_occ   <= 2'd1;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                    r_occ   <= 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            r_stall_cnt <= '0;
        else if (i_clear_count)
            r_stall_cnt <= '0;
        else if (w_stall)
            r_stall_cnt <= sat_inc(r_stall_cnt);
    end

    assign o_ready       = r_ready;
    assign o_valid       = r_valid;
    assign o_data        = r_main;
    assign o_occupancy   = r_occ;
    assign o_stall_count = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: accepted payloads are queued, a monitor checks every delivered payload.
// Direct checks cover reset, occupancy, backpressure, flush and the saturating stall counter.
module tb_pipe_stage_reg;

    localparam int              DW   = 64;
    localparam int              CW   = 4;
    localparam logic [DW-1:0]   RVAL = 64'h0000_0000_DEAD_BEEF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_valid;
    logic [DW-1:0] i_data;
    logic          o_ready;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          i_ready;
    logic          i_flush;
    logic          i_clear_count;
    logic [1:0]    o_occupancy;
    logic [CW-1:0] o_stall_count;

    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] exp_q[$];

    pipe_stage_reg #(
        .DATA_WIDTH (DW),
        .RESET_VALUE(RVAL),
        .CNT_WIDTH  (CW)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_valid      (i_valid),
        .i_data       (i_data),
        .o_ready      (o_ready),
        .o_valid      (o_valid),
        .o_data       (o_data),
        .i_ready      (i_ready),
        .i_flush      (i_flush),
        .i_clear_count(i_clear_count),
        .o_occupancy  (o_occupancy),
        .o_stall_count(o_stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus side: record each payload the DUT will accept at the coming edge.
    always @(negedge clk) begin
        if (rst_n && i_valid && o_ready && !i_flush)
            exp_q.push_back(i_data);
    end

    // Monitor: every payload consumed downstream must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n && o_valid && i_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL out_unexpected: got 0x%0h with no payload pending", o_data);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (o_data !== e) begin
                    n_errors++;
                    $display("FAIL out_order: got 0x%0h expected 0x%0h", o_data, e);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_ready = 1'b0;
        i_flush = 1'b0; i_clear_count = 1'b0;
        #12;
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_occ",   64'(o_occupancy), 64'd0);
        check("rst_cnt",   64'(o_stall_count), 64'd0);
        check("rst_data",  o_data, RVAL);
        rst_n = 1'b1;
        tick();

        // Streaming 1..4 at full rate
        i_ready = 1'b1;
        i_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            i_data = 64'(k);
            tick();
            check("stream_data", o_data, 64'(k));
            check("stream_occ",  64'(o_occupancy), 64'd1);
        end
        i_valid = 1'b0;
        tick();
        check("stream_drain_occ", 64'(o_occupancy), 64'd0);

        // Backpressure: A, B fill the buffer, C is refused until downstream drains
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 64'hA;
        tick();
        check("bp_occ1", 64'(o_occupancy), 64'd1);
        i_data = 64'hB;
        tick();
        check("bp_occ2",  64'(o_occupancy), 64'd2);
        check("bp_ready", 64'(o_ready), 64'd0);
        i_data = 64'hC;
        tick();
        check("bp_hold_data", o_data, 64'hA);
        check("bp_hold_occ",  64'(o_occupancy), 64'd2);
        check("bp_hold_vld",  64'(o_valid), 64'd1);
        i_ready = 1'b1;
        tick();
        check("bp_out_b", o_data, 64'hB);
        check("bp_ready_back", 64'(o_ready), 64'd1);
        tick();
        check("bp_out_c", o_data, 64'hC);
        i_valid = 1'b0;
        tick();
        check("bp_empty", 64'(o_valid), 64'd0);

        // Flush while FULL with a concurrent offer of 0xD
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 64'h11;
        tick();
        i_data = 64'h22;
        tick();
        check("fl_full", 64'(o_occupancy), 64'd2);
        i_flush = 1'b1;
        i_data  = 64'hD;
        tick();
        exp_q.delete();
        i_flush = 1'b0;
        i_valid = 1'b0;
        check("fl_valid", 64'(o_valid), 64'd0);
        check("fl_occ",   64'(o_occupancy), 64'd0);
        check("fl_ready", 64'(o_ready), 64'd1);
        i_ready = 1'b1;
        tick();
        tick();
        check("fl_no_0xd", 64'(o_valid), 64'd0);

        // In ONE with in_fire, out_fire and flush together
        i_valid = 1'b1;
        i_data  = 64'h31;
        tick();
        check("c6_one", 64'(o_occupancy), 64'd1);
        i_data  = 64'h32;
        i_flush = 1'b1;
        tick();
        exp_q.delete();
        i_flush = 1'b0;
        i_valid = 1'b0;
        check("c6_valid", 64'(o_valid), 64'd0);
        check("c6_occ",   64'(o_occupancy), 64'd0);
        tick();

        // Stall counter saturation at 15 with CNT_WIDTH=4
        i_clear_count = 1'b1;
        tick();
        i_clear_count = 1'b0;
        check("cnt_clear0", 64'(o_stall_count), 64'd0);
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 64'h55;
        tick();
        i_valid = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("cnt_5", 64'(o_stall_count), 64'd5);
        for (int k = 0; k < 15; k++) tick();
        check("cnt_sat", 64'(o_stall_count), 64'd15);
        check("cnt_hold_data", o_data, 64'h55);
        i_clear_count = 1'b1;
        tick();
        i_clear_count = 1'b0;
        check("cnt_clear", 64'(o_stall_count), 64'd0);
        i_ready = 1'b1;
        tick();
        check("cnt_drain", 64'(o_valid), 64'd0);

        // Reset asserted mid-stream while FULL
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 64'h77;
        tick();
        i_data = 64'h78;
        tick();
        check("mr_full", 64'(o_occupancy), 64'd2);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mr_valid", 64'(o_valid), 64'd0);
        check("mr_ready", 64'(o_ready), 64'd1);
        check("mr_occ",   64'(o_occupancy), 64'd0);
        check("mr_cnt",   64'(o_stall_count), 64'd0);
        check("mr_data",  o_data, RVAL);
        i_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        i_ready = 1'b1;
        tick();
        tick();
        check("mr_post_valid", 64'(o_valid), 64'd0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
